// File: rtl/seq_detector_param.sv
// Parametrised Mealy sequence detector with a runtime-loadable pattern,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_param #(
  parameter int              PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b0110,
  parameter int              CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bitstream,
  input  logic             bit_valid,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;

  // window doubles as the shifted history: its low PAT_W-1 bits are the next hist
  assign window = {hist, bitstream};

  assign out = !reset && !pat_load && bit_valid && (fill == FILL_MAX) && (window == pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= DEFAULT_PAT;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= window[PAT_W-2:0];
      if (out && !overlap_en)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      match_count <= '0;
    else if (count_clr)
      match_count <= out ? CNT_W'(1) : '0;
    else if (out && (match_count != '1))
      match_count <= match_count + 1'b1;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner
// sequences, then random stimulus against a queue-based reference model.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam logic [3:0] DEF_PAT = 4'b0110;

  logic       clk = 1'b0;
  logic       reset = 1'b1, bitstream = 1'b0, bit_valid = 1'b0, overlap_en = 1'b1;
  logic       pat_load = 1'b0, count_clr = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       out, out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .DEFAULT_PAT(4'b0110), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .bitstream(bitstream), .bit_valid(bit_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .count_clr(count_clr), .out(out), .match_count(match_count)
  );

  seq_detector_param #(.PAT_W(4), .DEFAULT_PAT(4'b0110), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .bitstream(bitstream), .bit_valid(bit_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .count_clr(count_clr), .out(out2), .match_count(match_count2)
  );

  int n_vec = 0, n_err = 0;

  // reference model: accepted bits since the last restart, oldest first
  int         q[$];
  logic [3:0] mpat = DEF_PAT;
  int         mcnt8 = 0, mcnt2 = 0;
  logic       m_out;
  logic       s_out, s_out2;
  int         s_cnt8, s_cnt2;

  typedef struct {
    bit r, v, b, o, l, c;
    bit ex_out;
    int ex_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic logic model_out();
    int w;
    if (reset || pat_load || !bit_valid || q.size() != PAT_W - 1) return 1'b0;
    w = 0;
    foreach (q[i]) w = w * 2 + q[i];
    w = w * 2 + int'(bitstream);
    return w == int'(mpat);
  endfunction

  function automatic int sat_inc(int c, int maxv);
    return (c >= maxv) ? maxv : c + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit o,
                      input bit l, input logic [3:0] p, input bit c);
    @(negedge clk);
    reset = r; bit_valid = v; bitstream = b; overlap_en = o;
    pat_load = l; pat_in = p; count_clr = c;
    #1;
    s_out  = out;
    s_out2 = out2;
    m_out  = model_out();
    if (r) begin
      mpat = DEF_PAT; q.delete(); mcnt8 = 0; mcnt2 = 0;
    end else begin
      if (l) begin
        mpat = p; q.delete();
      end else if (v) begin
        if (m_out && !o) q.delete();
        else begin
          q.push_back(int'(b));
          if (q.size() > PAT_W - 1) void'(q.pop_front());
        end
      end
      if (c) begin
        mcnt8 = m_out ? 1 : 0; mcnt2 = m_out ? 1 : 0;
      end else if (m_out) begin
        mcnt8 = sat_inc(mcnt8, 255); mcnt2 = sat_inc(mcnt2, 3);
      end
    end
    @(posedge clk);
    #1;
    s_cnt8 = int'(match_count);
    s_cnt2 = int'(match_count2);
  endtask

  task automatic add(input bit r, input bit v, input bit b, input bit o,
                     input bit eo, input int ec);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.o = o; t.l = 1'b0; t.c = 1'b0;
    t.ex_out = eo; t.ex_cnt = ec;
    tbl.push_back(t);
  endtask

  initial begin
    // overlapping, default pattern: 0,1,1,0,1,1,0
    add(1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0); add(0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 1); add(0, 1, 1, 1, 0, 1); add(0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 1, 1, 2);
    // non-overlapping: 0,1,1,0,1,1,0,0,1,1,0
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1); add(0, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1); add(0, 1, 0, 0, 1, 2);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].o, tbl[i].l, 4'b0000, tbl[i].c);
      chk($sformatf("table out row %0d", i), s_out, tbl[i].ex_out);
      chk($sformatf("table count row %0d", i), s_cnt8, tbl[i].ex_cnt);
    end

    // gaps with bit_valid low
    step(1, 0, 0, 1, 0, 0, 0);
    chk("reset count", s_cnt8, 0);
    step(0, 1, 0, 1, 0, 0, 0); chk("gap first bit out", s_out, 0);
    step(0, 0, 0, 1, 0, 0, 0); chk("gap1 out", s_out, 0);
    step(0, 1, 1, 1, 0, 0, 0); chk("gap bit2 out", s_out, 0);
    step(0, 1, 1, 1, 0, 0, 0); chk("gap bit3 out", s_out, 0);
    step(0, 0, 0, 1, 0, 0, 0); chk("gap2 out", s_out, 0);
    step(0, 1, 0, 1, 0, 0, 0); chk("gap final out", s_out, 1);
    chk("gap count", s_cnt8, 1);

    // runtime pattern load discards prior history
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 4'b1111, 0); chk("load cycle out", s_out, 0);
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, 1, 1, 0, 4'b0000, 0);
      chk($sformatf("ones #%0d out", i), s_out, (i >= 4) ? 1 : 0);
    end
    chk("load count", s_cnt8, 4);

    // saturation of the narrow counter, then clear coincident with a match
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 0, 1, 0, 0, 0);
    end
    chk("sat count narrow", s_cnt2, 3);
    chk("sat count wide", s_cnt8, 5);
    step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 1);
    chk("clr match out", s_out2, 1);
    chk("clr match count narrow", s_cnt2, 1);
    chk("clr match count wide", s_cnt8, 1);

    // reset mid-stream, and pattern returns to the default after a load
    step(0, 1, 0, 1, 1, 4'b1001, 0);
    step(0, 1, 0, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0); chk("out during reset", s_out, 0);
    step(0, 1, 0, 1, 0, 0, 0); chk("post-reset bit out", s_out, 0);
    chk("post-reset count", s_cnt8, 0);
    step(0, 1, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0); chk("default pattern restored", s_out, 1);

    // random stimulus against the reference model
    step(1, 0, 0, 1, 0, 0, 0);
    begin
      bit o;
      o = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        bit r, v, l, c;
        r = ($urandom_range(0, 99) == 0);
        l = ($urandom_range(0, 39) == 0);
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 7) == 0) o = ~o;
        step(r, v, 1'($urandom), o, l, 4'($urandom), c);
        chk("rand out", s_out, m_out);
        chk("rand out narrow", s_out2, m_out);
        chk("rand count", s_cnt8, mcnt8);
        chk("rand count narrow", s_cnt2, mcnt2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
